inst_prefetch_buffer: RTL and testbench

// Sits between the openmips fetch port (rom_ce_o/rom_addr_o/rom_data_i) and a

---
 rtl/inst_prefetch_buffer_if.sv | 27 ++
 rtl/inst_prefetch_buffer.sv | 138 +++++++++++++
 tb/tb_inst_prefetch_buffer.sv | 350 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_prefetch_buffer_if.sv
// Fetch-port and memory-port signals of the instruction prefetch buffer.
// The slave modport is the prefetch buffer itself. The master modport is the
// environment, meaning the CPU fetch stage together with the instruction memory.
interface inst_prefetch_buffer_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              cpu_ce_i;
   logic [ADDR_W-1:0] cpu_addr_i;
   logic [DATA_W-1:0] cpu_inst_o;
   logic              cpu_valid_o;
   logic              cpu_stall_o;
   logic              mem_req_o;
   logic [ADDR_W-1:0] mem_addr_o;
   logic              mem_ack_i;
   logic [DATA_W-1:0] mem_data_i;

   modport slave (
      input  cpu_ce_i, cpu_addr_i, mem_ack_i, mem_data_i,
      output cpu_inst_o, cpu_valid_o, cpu_stall_o, mem_req_o, mem_addr_o
   );

   modport master (
      output cpu_ce_i, cpu_addr_i, mem_ack_i, mem_data_i,
      input  cpu_inst_o, cpu_valid_o, cpu_stall_o, mem_req_o, mem_addr_o
   );
endinterface

// File: rtl/inst_prefetch_buffer.sv
// Sequential instruction prefetch buffer between the openmips fetch port and a
// req/ack instruction memory. Words are prefetched into a DEPTH-entry FIFO of
// {addr, inst}. The CPU is served only from the FIFO head. Any fetch address
// that is neither the head nor the pending request flushes the FIFO and
// restarts fetching there. A request already in flight at a redirect is
// drained and its data is discarded.
module inst_prefetch_buffer #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4
) (
   input logic                   clk,
   input logic                   rst,
   inst_prefetch_buffer_if.slave bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [ADDR_W-1:0] WORD_STEP = ADDR_W'(4);
   localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(DEPTH);

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

   state_t            state, state_nxt;
   logic              req, req_nxt;
   logic [ADDR_W-1:0] req_addr, req_addr_nxt;
   logic [ADDR_W-1:0] fetch_addr, fetch_addr_nxt;

   logic [ADDR_W-1:0] fifo_addr [DEPTH];
   logic [DATA_W-1:0] fifo_inst [DEPTH];
   logic [PTR_W-1:0]  rd_ptr, wr_ptr;
   logic [CNT_W-1:0]  count;

   logic             hit, pend_match, waiting, redirect;
   logic             room, room_after, push, pop;
   logic [CNT_W-1:0] count_after;

   // Lookup against the FIFO head and the request in flight.
   assign hit        = bus.cpu_ce_i && (count != '0) && (fifo_addr[rd_ptr] == bus.cpu_addr_i);
   assign pend_match = (count == '0) && (state == FETCH) && (req_addr == bus.cpu_addr_i);
   assign waiting    = (state != FETCH) && (fetch_addr == bus.cpu_addr_i);
   assign redirect   = bus.cpu_ce_i && !hit && !pend_match && !waiting;
   assign pop        = hit;

   // An outstanding request owns a FIFO slot, so an ack can never overflow.
   assign room        = (count + CNT_W'(state == FETCH)) < DEPTH_C;
   assign count_after = count + CNT_W'(1) - CNT_W'(pop);
   assign room_after  = count_after < DEPTH_C;

   assign bus.cpu_valid_o = hit;
   assign bus.cpu_inst_o  = hit ? fifo_inst[rd_ptr] : '0;
   assign bus.cpu_stall_o = bus.cpu_ce_i && !hit;
   assign bus.mem_req_o   = req;
   assign bus.mem_addr_o  = req_addr;

   // Next state of the request FSM and the fetch pointer.
   always_comb begin
      // NOTE: every signal gets a default first, so no path leaves one unassigned and no latch is inferred.
      state_nxt      = state;
      req_nxt        = req;
      req_addr_nxt   = req_addr;
      fetch_addr_nxt = fetch_addr;
      push           = 1'b0;
      if (redirect) begin
         fetch_addr_nxt = bus.cpu_addr_i;
      end
      unique case (state)
         IDLE: begin
            if (bus.cpu_ce_i && room && !redirect) begin
               req_nxt      = 1'b1;
               req_addr_nxt = fetch_addr;
               state_nxt    = FETCH;
            end
         end
         FETCH: begin
            if (bus.mem_ack_i) begin
               req_nxt   = 1'b0;
               state_nxt = IDLE;
               // A redirect on the ack edge discards the returning word.
               if (!redirect) begin
                  push           = 1'b1;
                  fetch_addr_nxt = req_addr + WORD_STEP;
                  if (bus.cpu_ce_i && room_after) begin
                     req_nxt      = 1'b1;
                     req_addr_nxt = req_addr + WORD_STEP;
                     state_nxt    = FETCH;
                  end
               end
            end else if (redirect) begin
               state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            if (bus.mem_ack_i) begin
               req_nxt   = 1'b0;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Control registers and FIFO pointers, synchronous active-low reset.
   always_ff @(posedge clk) begin
      // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
      if (!rst) begin
         state      <= IDLE;
         req        <= 1'b0;
         req_addr   <= '0;
         fetch_addr <= '0;
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         count      <= '0;
      end else begin
         state      <= state_nxt;
         req        <= req_nxt;
         req_addr   <= req_addr_nxt;
         fetch_addr <= fetch_addr_nxt;
         if (redirect) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
         end
      end
   end

   // FIFO storage write port.
   always_ff @(posedge clk) begin
      // NOTE: storage is not reset; the pointers and count alone decide which entries are valid.
      if (push) begin
         fifo_addr[wr_ptr] <= req_addr;
         fifo_inst[wr_ptr] <= bus.mem_data_i;
      end
   end
endmodule

// File: tb/tb_inst_prefetch_buffer.sv
// Directed testbench for inst_prefetch_buffer. A behavioural memory returns
// addr ^ 0xA5A5A5A5 on the second edge after each request. Inputs are driven
// on the falling edge and outputs are sampled 1 ns later.
module tb_inst_prefetch_buffer;
   localparam logic [31:0] KEY = 32'hA5A5_A5A5;

   logic        clk = 1'b0;
   logic        rst;
   int          checks = 0;
   int          errors = 0;
   logic [31:0] ack_log [$];

   inst_prefetch_buffer_if bus ();

   inst_prefetch_buffer dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Memory model: seen at one falling edge, acked at the next, one-cycle pulse.
   initial begin
      bit busy;
      busy           = 1'b0;
      bus.mem_ack_i  = 1'b0;
      bus.mem_data_i = '0;
      forever begin
         @(negedge clk);
         if (bus.mem_ack_i) begin
            bus.mem_ack_i = 1'b0;
            busy          = 1'b0;
         end else if (busy) begin
            bus.mem_ack_i  = 1'b1;
            bus.mem_data_i = bus.mem_addr_o ^ KEY;
            ack_log.push_back(bus.mem_addr_o);
         end
         if (!busy && bus.mem_req_o) busy = 1'b1;
      end
   end

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      bus.cpu_ce_i   = 1'b0;
      bus.cpu_addr_i = '0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
   endtask

   // Present addr, wait for the first valid cycle, check the word, let it pop.
   task automatic fetch_word(input logic [31:0] addr);
      int n;
      bus.cpu_ce_i   = 1'b1;
      bus.cpu_addr_i = addr;
      #1;
      n = 0;
      while (!bus.cpu_valid_o && n < 20) begin
         @(negedge clk);
         #1;
         n++;
      end
      checks++;
      if (!bus.cpu_valid_o) begin
         errors++;
         $display("FAIL fetch_timeout addr=%h: cpu_valid_o=0 after %0d cycles, expected 1", addr, n);
      end else if (bus.cpu_inst_o !== (addr ^ KEY)) begin
         errors++;
         $display("FAIL fetch_data addr=%h: got %h, expected %h", addr, bus.cpu_inst_o, addr ^ KEY);
      end
      @(negedge clk);
   endtask

   // Leaves the FIFO holding 0x0..0xC, IDLE, fetch_addr 0x10, cpu_ce_i low.
   task automatic fill_fifo();
      for (int i = 0; i < 4; i++) begin
         int n;
         bus.cpu_ce_i   = 1'b1;
         bus.cpu_addr_i = 32'(i * 4);
         @(negedge clk);
         #1;
         checks++;
         if (bus.mem_req_o !== 1'b1 || bus.mem_addr_o !== 32'(i * 4)) begin
            errors++;
            $display("FAIL fill_req %0d: req=%b addr=%h, expected req=1 addr=%h", i, bus.mem_req_o, bus.mem_addr_o, 32'(i * 4));
         end
         bus.cpu_ce_i = 1'b0;
         n = 0;
         while (bus.mem_req_o && n < 10) begin
            @(negedge clk);
            #1;
            n++;
         end
         checks++;
         if (bus.mem_req_o !== 1'b0) begin
            errors++;
            $display("FAIL fill_ack %0d: req=%b after %0d cycles, expected 0", i, bus.mem_req_o, n);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      bus.cpu_ce_i   = 1'b1;
      bus.cpu_addr_i = 32'h40;
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if (bus.cpu_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, expected 0", bus.cpu_valid_o); end
      checks++;
      if (bus.cpu_inst_o !== 32'h0) begin errors++; $display("FAIL reset_inst: got %h, expected 0", bus.cpu_inst_o); end
      checks++;
      if (bus.cpu_stall_o !== 1'b1) begin errors++; $display("FAIL reset_stall_ce1: got %b, expected 1", bus.cpu_stall_o); end
      checks++;
      if (bus.mem_req_o !== 1'b0) begin errors++; $display("FAIL reset_req: got %b, expected 0", bus.mem_req_o); end
      checks++;
      if (bus.mem_addr_o !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h, expected 0", bus.mem_addr_o); end
      bus.cpu_ce_i = 1'b0;
      #1;
      checks++;
      if (bus.cpu_stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall_ce0: got %b, expected 0", bus.cpu_stall_o); end
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_sequential();
      do_reset();
      ack_log.delete();
      bus.cpu_ce_i   = 1'b1;
      bus.cpu_addr_i = 32'h0;
      @(negedge clk);
      #1;
      checks++;
      if (bus.mem_req_o !== 1'b1 || bus.mem_addr_o !== 32'h0 || bus.cpu_stall_o !== 1'b1) begin
         errors++;
         $display("FAIL seq_first_req: req=%b addr=%h stall=%b, expected 1/0/1", bus.mem_req_o, bus.mem_addr_o, bus.cpu_stall_o);
      end
      for (int i = 0; i < 16; i++) fetch_word(32'(i * 4));
      bus.cpu_ce_i = 1'b0;
      checks++;
      if (ack_log.size() < 16) begin
         errors++;
         $display("FAIL seq_ack_count: got %0d acks, expected at least 16", ack_log.size());
      end
      for (int i = 0; i < 16 && i < ack_log.size(); i++) begin
         checks++;
         if (ack_log[i] !== 32'(i * 4)) begin
            errors++;
            $display("FAIL seq_mem_addr %0d: got %h, expected %h", i, ack_log[i], 32'(i * 4));
         end
      end
   endtask

   task automatic test_full_idle();
      do_reset();
      fill_fifo();
      bus.cpu_ce_i   = 1'b1;
      bus.cpu_addr_i = 32'h10;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1;
         checks++;
         if (bus.mem_req_o !== 1'b0 || bus.cpu_valid_o !== 1'b0 || bus.cpu_stall_o !== 1'b1) begin
            errors++;
            $display("FAIL full_hold %0d: req=%b valid=%b stall=%b, expected 0/0/1", i, bus.mem_req_o, bus.cpu_valid_o, bus.cpu_stall_o);
         end
      end
      bus.cpu_addr_i = 32'h0;
      #1;
      checks++;
      if (bus.cpu_valid_o !== 1'b1 || bus.cpu_inst_o !== (32'h0 ^ KEY)) begin
         errors++;
         $display("FAIL full_head: valid=%b inst=%h, expected 1/%h", bus.cpu_valid_o, bus.cpu_inst_o, 32'h0 ^ KEY);
      end
      @(negedge clk);
      bus.cpu_addr_i = 32'h10;
      @(negedge clk);
      #1;
      checks++;
      if (bus.mem_req_o !== 1'b1 || bus.mem_addr_o !== 32'h10) begin
         errors++;
         $display("FAIL full_req_after_pop: req=%b addr=%h, expected 1/00000010", bus.mem_req_o, bus.mem_addr_o);
      end
      fetch_word(32'h4);
      fetch_word(32'h8);
      fetch_word(32'hC);
      fetch_word(32'h10);
      bus.cpu_ce_i = 1'b0;
   endtask

   task automatic test_redirect_full();
      do_reset();
      fill_fifo();
      bus.cpu_ce_i   = 1'b1;
      bus.cpu_addr_i = 32'h100;
      #1;
      checks++;
      if (bus.cpu_valid_o !== 1'b0) begin errors++; $display("FAIL redir_full_valid: got %b, expected 0", bus.cpu_valid_o); end
      @(negedge clk);
      #1;
      checks++;
      if (bus.mem_req_o !== 1'b0) begin errors++; $display("FAIL redir_full_edge: req=%b, expected 0", bus.mem_req_o); end
      @(negedge clk);
      #1;
      checks++;
      if (bus.mem_req_o !== 1'b1 || bus.mem_addr_o !== 32'h100) begin
         errors++;
         $display("FAIL redir_full_req: req=%b addr=%h, expected 1/00000100", bus.mem_req_o, bus.mem_addr_o);
      end
      fetch_word(32'h100);
      fetch_word(32'h104);
      bus.cpu_ce_i = 1'b0;
   endtask

   task automatic test_redirect_inflight();
      do_reset();
      bus.cpu_ce_i   = 1'b1;
      bus.cpu_addr_i = 32'h10;
      @(negedge clk);
      #1;
      checks++;
      if (bus.mem_req_o !== 1'b0) begin errors++; $display("FAIL drain_redirect_edge: req=%b, expected 0", bus.mem_req_o); end
      @(negedge clk);
      #1;
      checks++;
      if (bus.mem_req_o !== 1'b1 || bus.mem_addr_o !== 32'h10) begin
         errors++;
         $display("FAIL drain_first_req: req=%b addr=%h, expected 1/00000010", bus.mem_req_o, bus.mem_addr_o);
      end
      bus.cpu_addr_i = 32'h200;
      @(negedge clk);
      #1;
      checks++;
      if (bus.mem_req_o !== 1'b1 || bus.mem_addr_o !== 32'h10 || bus.cpu_valid_o !== 1'b0) begin
         errors++;
         $display("FAIL drain_hold: req=%b addr=%h valid=%b, expected 1/00000010/0", bus.mem_req_o, bus.mem_addr_o, bus.cpu_valid_o);
      end
      @(negedge clk);
      #1;
      checks++;
      if (bus.mem_req_o !== 1'b0 || bus.cpu_valid_o !== 1'b0) begin
         errors++;
         $display("FAIL drain_drop: req=%b valid=%b, expected 0/0", bus.mem_req_o, bus.cpu_valid_o);
      end
      @(negedge clk);
      #1;
      checks++;
      if (bus.mem_req_o !== 1'b1 || bus.mem_addr_o !== 32'h200) begin
         errors++;
         $display("FAIL drain_new_req: req=%b addr=%h, expected 1/00000200", bus.mem_req_o, bus.mem_addr_o);
      end
      fetch_word(32'h200);
      bus.cpu_ce_i = 1'b0;
   endtask

   task automatic test_wrap();
      do_reset();
      ack_log.delete();
      fetch_word(32'hFFFF_FFF8);
      fetch_word(32'hFFFF_FFFC);
      fetch_word(32'h0000_0000);
      bus.cpu_ce_i = 1'b0;
      checks++;
      if (ack_log.size() < 3) begin
         errors++;
         $display("FAIL wrap_ack_count: got %0d acks, expected at least 3", ack_log.size());
      end else begin
         checks++;
         if (ack_log[0] !== 32'hFFFF_FFF8 || ack_log[1] !== 32'hFFFF_FFFC || ack_log[2] !== 32'h0) begin
            errors++;
            $display("FAIL wrap_mem_addr: got %h %h %h, expected fffffff8 fffffffc 00000000", ack_log[0], ack_log[1], ack_log[2]);
         end
      end
   endtask

   task automatic test_reset_mid_fetch();
      do_reset();
      bus.cpu_ce_i   = 1'b1;
      bus.cpu_addr_i = 32'h0;
      @(negedge clk);
      #1;
      checks++;
      if (bus.mem_req_o !== 1'b1 || bus.mem_addr_o !== 32'h0) begin
         errors++;
         $display("FAIL rstmid_req: req=%b addr=%h, expected 1/00000000", bus.mem_req_o, bus.mem_addr_o);
      end
      rst = 1'b0;
      bus.cpu_ce_i = 1'b0;
      @(negedge clk);
      #1;
      checks++;
      if (bus.mem_req_o !== 1'b0 || bus.mem_addr_o !== 32'h0) begin
         errors++;
         $display("FAIL rstmid_cleared: req=%b addr=%h, expected 0/00000000", bus.mem_req_o, bus.mem_addr_o);
      end
      rst = 1'b1;
      @(negedge clk);
      #1;
      checks++;
      if (bus.mem_req_o !== 1'b0) begin errors++; $display("FAIL rstmid_late_ack_req: req=%b, expected 0", bus.mem_req_o); end
      bus.cpu_ce_i   = 1'b1;
      bus.cpu_addr_i = 32'h0;
      #1;
      checks++;
      if (bus.cpu_valid_o !== 1'b0) begin errors++; $display("FAIL rstmid_no_push: valid=%b, expected 0", bus.cpu_valid_o); end
      @(negedge clk);
      #1;
      checks++;
      if (bus.mem_req_o !== 1'b1 || bus.mem_addr_o !== 32'h0 || bus.cpu_valid_o !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_rerequest: req=%b addr=%h valid=%b, expected 1/00000000/0", bus.mem_req_o, bus.mem_addr_o, bus.cpu_valid_o);
      end
      @(negedge clk);
      #1;
      checks++;
      if (bus.cpu_valid_o !== 1'b0) begin errors++; $display("FAIL rstmid_no_bypass: valid=%b during ack cycle, expected 0", bus.cpu_valid_o); end
      @(negedge clk);
      #1;
      checks++;
      if (bus.cpu_valid_o !== 1'b1 || bus.cpu_inst_o !== (32'h0 ^ KEY)) begin
         errors++;
         $display("FAIL rstmid_after_ack: valid=%b inst=%h, expected 1/%h", bus.cpu_valid_o, bus.cpu_inst_o, 32'h0 ^ KEY);
      end
      @(negedge clk);
      bus.cpu_ce_i = 1'b0;
   endtask

   initial begin
      rst            = 1'b0;
      bus.cpu_ce_i   = 1'b0;
      bus.cpu_addr_i = '0;
      test_reset();
      test_sequential();
      test_full_idle();
      test_redirect_full();
      test_redirect_inflight();
      test_wrap();
      test_reset_mid_fetch();
      repeat (4) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within 200000 ns");
      $fatal(1, "watchdog expired");
   end
endmodule
